// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
//
// Parameterised serial pattern detector. One bit of the serial stream is
// accepted per clock while en is high; the block flags the accepted bit that
// completes a LEN-bit pattern. The active pattern starts as PATTERN and can be
// replaced at run time with pat_load/pat_in. Overlapping or non-overlapping
// detection is chosen with OVERLAP.
//
// Parameters
//   LEN      pattern length in bits, 2..32
//   PATTERN  pattern after reset; MSB is the first bit received
//   OVERLAP  1: trailing bits of a match may begin the next match
//            0: history is discarded after every match
//   CNT_W    width of the saturating match counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   en         qualifies x; when low every piece of state holds
//   x          serial data bit
//   pat_load   load pat_in as the active pattern on this edge (beats en)
//   pat_in     new pattern, MSB first
//   z          Mealy match: the current en-qualified x completes the pattern
//   z_q        z registered on the accepting edge
//   match_cnt  number of matches since reset, saturating at all-ones
//   cnt_sat    sticky flag: a match arrived while match_cnt was all-ones
//
// Structure
//   The detector keeps the last LEN-1 accepted bits (hist) and a fill count
//   of how many of them are valid. A match is a full-window compare of
//   {hist, x} against the pattern once fill has reached LEN-1. Because fill
//   saturates and the compare spans the whole window, this behaves exactly
//   like a KMP automaton with states S0..S(LEN-1) without needing explicit
//   failure transitions, and it stays correct for any pattern loaded at run
//   time.
// ---------------------------------------------------------------------------
module seq_detect_param #(
    parameter int                LEN     = 6,
    parameter logic [LEN-1:0]    PATTERN = 6'b101010,
    parameter bit                OVERLAP = 1'b1,
    parameter int                CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             pat_load,
    input  logic [LEN-1:0]   pat_in,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // hist holds LEN-1 bits; fill counts 0..LEN-1 valid bits in it.
    localparam int HIST_W = LEN - 1;
    localparam int FILL_W = (LEN > 2) ? $clog2(LEN) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    logic [LEN-1:0]    pat_q,   pat_d;
    logic [HIST_W-1:0] hist_q,  hist_d;
    logic [FILL_W-1:0] fill_q,  fill_d;
    logic              zreg_q,  zreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              sat_q,   sat_d;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    logic              accept;      // x is taken into the stream this cycle
    logic              hist_full;   // hist holds LEN-1 valid bits
    logic [LEN-1:0]    window;      // candidate pattern ending in x
    logic [HIST_W-1:0] hist_shift;  // hist after shifting x in
    logic              match;

    // pat_load takes priority: the bit presented with a load is dropped.
    assign accept    = en & ~pat_load;
    assign hist_full = (fill_q == FILL_FULL);
    assign window    = {hist_q, x};
    assign match     = accept & hist_full & (window == pat_q);

    // A one-bit history has no older bits to keep, so the shift degenerates
    // to a plain load of x.
    generate
        if (HIST_W == 1) begin : g_hist_short
            assign hist_shift = x;
        end else begin : g_hist_long
            assign hist_shift = {hist_q[HIST_W-2:0], x};
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no
        // path through the branches below can leave one unassigned and infer
        // a latch.
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        zreg_d = zreg_q;
        cnt_d  = cnt_q;
        sat_d  = sat_q;

        if (pat_load) begin
            // Restart detection against the new pattern; stale history is
            // ignored because fill drops to zero.
            pat_d  = pat_in;
            fill_d = '0;
            zreg_d = 1'b0;
        end else if (en) begin
            hist_d = hist_shift;
            zreg_d = match;

            if (match && !OVERLAP) begin
                // Non-overlapping: the next match needs LEN fresh bits.
                fill_d = '0;
            end else if (!hist_full) begin
                fill_d = fill_q + FILL_ONE;
            end

            if (match) begin
                if (cnt_q == '1) begin
                    sat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            zreg_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            zreg_q <= zreg_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign z         = match;
    assign z_q       = zreg_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
//
// Three detectors share one stimulus stream:
//   u_ov   defaults (LEN 6, pattern 101010, OVERLAP 1, CNT_W 8)
//   u_nov  OVERLAP 0
//   u_sat  OVERLAP 0, CNT_W 2
// Each table row carries the inputs for one clock and the hand-derived z of
// the overlapping and non-overlapping detectors (u_sat shares u_nov's z).
// Expected z_q, match_cnt and cnt_sat follow from those z values; milestone
// counter values are also checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       x;
    logic       pat_load;
    logic [5:0] pat_in;

    logic       z_ov,  zq_ov,  sat_ov;
    logic       z_nov, zq_nov, sat_nov;
    logic       z_sat, zq_sat, sat_sat;
    logic [7:0] cnt_ov, cnt_nov;
    logic [1:0] cnt_sat2;

    seq_detect_param u_ov (
        .clk(clk), .rst(rst), .en(en), .x(x),
        .pat_load(pat_load), .pat_in(pat_in),
        .z(z_ov), .z_q(zq_ov), .match_cnt(cnt_ov), .cnt_sat(sat_ov)
    );

    seq_detect_param #(.OVERLAP(1'b0)) u_nov (
        .clk(clk), .rst(rst), .en(en), .x(x),
        .pat_load(pat_load), .pat_in(pat_in),
        .z(z_nov), .z_q(zq_nov), .match_cnt(cnt_nov), .cnt_sat(sat_nov)
    );

    seq_detect_param #(.OVERLAP(1'b0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .x(x),
        .pat_load(pat_load), .pat_in(pat_in),
        .z(z_sat), .z_q(zq_sat), .match_cnt(cnt_sat2), .cnt_sat(sat_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic en;
        logic x;
        logic ld;
        logic zo;   // expected z, overlapping detector
        logic zn;   // expected z, non-overlapping detectors
    } vec_t;

    vec_t tbl[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Expected registered outputs, advanced from the table's z values.
    logic       m_zq_ov,  m_zq_nov;
    logic [7:0] m_cnt_ov, m_cnt_nov;
    logic [1:0] m_cnt_s;
    logic       m_sat_s;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic e, input logic b, input logic l,
                       input logic zo, input logic zn);
        vec_t v;
        v.rst = r; v.en = e; v.x = b; v.ld = l; v.zo = zo; v.zn = zn;
        tbl.push_back(v);
    endtask

    task automatic model_clear();
        m_zq_ov = 1'b0; m_zq_nov = 1'b0;
        m_cnt_ov = '0;  m_cnt_nov = '0;
        m_cnt_s = '0;   m_sat_s = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " z_q ov"},       32'(zq_ov),    32'(m_zq_ov));
        check({tag, " z_q nov"},      32'(zq_nov),   32'(m_zq_nov));
        check({tag, " z_q sat"},      32'(zq_sat),   32'(m_zq_nov));
        check({tag, " cnt ov"},       32'(cnt_ov),   32'(m_cnt_ov));
        check({tag, " cnt nov"},      32'(cnt_nov),  32'(m_cnt_nov));
        check({tag, " cnt sat"},      32'(cnt_sat2), 32'(m_cnt_s));
        check({tag, " cnt_sat flag"}, 32'(sat_sat),  32'(m_sat_s));
        check({tag, " cnt_sat ov"},   32'(sat_ov),   32'(0));
    endtask

    task automatic apply(input int idx);
        vec_t  v;
        string tag;
        v   = tbl[idx];
        tag = $sformatf("row%0d", idx);
        @(negedge clk);
        rst = v.rst; en = v.en; x = v.x; pat_load = v.ld;
        #1;
        if (v.rst) model_clear();
        check({tag, " z ov"},  32'(z_ov),  32'(v.zo));
        check({tag, " z nov"}, 32'(z_nov), 32'(v.zn));
        check({tag, " z sat"}, 32'(z_sat), 32'(v.zn));
        // Reset clears the registered outputs immediately, before any edge.
        if (v.rst) check_regs({tag, " async"});
        @(posedge clk);
        #1;
        if (!v.rst) begin
            if (v.en || v.ld) begin
                m_zq_ov  = v.zo;
                m_zq_nov = v.zn;
            end
            if (v.zo) m_cnt_ov  = m_cnt_ov + 8'd1;
            if (v.zn) m_cnt_nov = m_cnt_nov + 8'd1;
            if (v.zn) begin
                if (m_cnt_s == 2'd3) m_sat_s = 1'b1;
                else                 m_cnt_s = m_cnt_s + 2'd1;
            end
        end
        check_regs(tag);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) apply(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seg_a, seg_b, seg_c1, seg_c2, seg_d, seg_e, seg_end;
        logic [11:0] s;

        // A: 101010101010, both modes
        for (int i = 1; i <= 12; i++)
            row(0, 1, (i % 2 == 1), 0, (i >= 6 && i % 2 == 0), (i % 6 == 0));
        seg_a = tbl.size();

        // B: 101, five idle cycles with x wiggling, then 010
        row(1, 0, 0, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0);
        row(0, 1, 0, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) row(0, 0, (k % 2 == 0), 0, 0, 0);
        row(0, 1, 0, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0);
        row(0, 1, 0, 0, 1, 1);
        seg_b = tbl.size();

        // C: 10101 continuing the stream (overlap re-matches on each 0),
        // then rst together with a 0 bit
        row(0, 1, 1, 0, 0, 0);
        row(0, 1, 0, 0, 1, 0);
        row(0, 1, 1, 0, 0, 0);
        row(0, 1, 0, 0, 1, 0);
        row(0, 1, 1, 0, 0, 0);
        row(1, 1, 0, 0, 0, 0);
        seg_c1 = tbl.size();
        for (int i = 1; i <= 6; i++)
            row(0, 1, (i % 2 == 1), 0, (i == 6), (i == 6));
        seg_c2 = tbl.size();

        // D: one more 1, then pat_load on a bit that would complete an
        // overlapping match, then 101010111000 against the new pattern
        row(0, 1, 1, 0, 0, 0);
        row(0, 1, 0, 1, 0, 0);
        s = 12'b101010111000;
        for (int i = 11; i >= 0; i--)
            row(0, 1, s[i], 0, (i == 0), (i == 0));
        seg_d = tbl.size();

        // E: reset (pattern back to 101010), five 101010 frames
        row(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 30; i++)
            row(0, 1, (i % 2 == 1), 0, (i >= 6 && i % 2 == 0), (i % 6 == 0));
        seg_e = tbl.size();
        for (int k = 0; k < 3; k++) row(0, 0, 1, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0);
        seg_end = tbl.size();

        // Reset state
        rst = 1'b1; en = 1'b0; x = 1'b0; pat_load = 1'b0; pat_in = 6'b111000;
        model_clear();
        #12;
        check("reset z ov",  32'(z_ov),  32'(0));
        check("reset z nov", 32'(z_nov), 32'(0));
        check_regs("reset");

        run_rows(0, seg_a);
        check("A cnt ov",  32'(cnt_ov),  32'(4));
        check("A cnt nov", 32'(cnt_nov), 32'(2));

        run_rows(seg_a, seg_b);
        check("B cnt ov",  32'(cnt_ov),   32'(1));
        check("B cnt nov", 32'(cnt_nov),  32'(1));
        check("B cnt sat", 32'(cnt_sat2), 32'(1));

        run_rows(seg_b, seg_c1);
        check("C rst cnt ov",  32'(cnt_ov),  32'(0));
        check("C rst cnt nov", 32'(cnt_nov), 32'(0));
        run_rows(seg_c1, seg_c2);
        check("C fresh cnt ov",  32'(cnt_ov),  32'(1));
        check("C fresh cnt nov", 32'(cnt_nov), 32'(1));

        run_rows(seg_c2, seg_d);
        check("D cnt ov",  32'(cnt_ov),   32'(2));
        check("D cnt nov", 32'(cnt_nov),  32'(2));
        check("D cnt sat", 32'(cnt_sat2), 32'(2));

        run_rows(seg_d, seg_e);
        check("E cnt ov",       32'(cnt_ov),   32'(13));
        check("E cnt nov",      32'(cnt_nov),  32'(5));
        check("E cnt sat",      32'(cnt_sat2), 32'(3));
        check("E cnt_sat flag", 32'(sat_sat),  32'(1));

        run_rows(seg_e, seg_end);
        check("end cnt_sat flag", 32'(sat_sat),  32'(0));
        check("end cnt sat",      32'(cnt_sat2), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
